// File: rtl/sweep_pkg.sv
// Shared types and helpers for the linear frequency-sweep sequencer.
//   mode_e     : sweep behaviour once the endpoint has been held one dwell
//   state_e    : controller FSM states
//   norm_dwell : maps a dwell of 0 onto 1 so every step lasts at least a cycle
//   to_mode    : decodes the raw 2-bit mode field (3 falls back to SINGLE)
package sweep_pkg;

    typedef enum logic [1:0] {
        SINGLE = 2'd0,
        REPEAT = 2'd1,
        BOUNCE = 2'd2
    } mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } state_e;

    function automatic logic [31:0] norm_dwell(input logic [31:0] dwell);
        return (dwell == 32'd0) ? 32'd1 : dwell;
    endfunction

    function automatic mode_e to_mode(input logic [1:0] raw);
        case (raw)
            2'd1:    return REPEAT;
            2'd2:    return BOUNCE;
            default: return SINGLE;
        endcase
    endfunction

endpackage

// File: rtl/sweep_controller_if.sv
// Control/status bundle between the register interface and the sweep
// controller.
//   i_start / i_abort        : start pulse, abort request
//   i_mode                   : 0 single, 1 repeat, 2 bounce, 3 single
//   i_start_step/i_stop_step : sweep endpoints (unsigned)
//   i_delta / i_dwell        : increment per period, cycles per step value
//   o_step_size              : step value driven to the generator
//   o_busy / o_done / o_wrap : status and one-cycle event pulses
// master drives the configuration side, slave is the controller.
interface sweep_controller_if #(
    parameter int STEP_W      = 24,
    parameter int DWELL_WIDTH = 16
) ();

    logic                   i_start;
    logic                   i_abort;
    logic [1:0]             i_mode;
    logic [STEP_W-1:0]      i_start_step;
    logic [STEP_W-1:0]      i_stop_step;
    logic [STEP_W-1:0]      i_delta;
    logic [DWELL_WIDTH-1:0] i_dwell;
    logic [STEP_W-1:0]      o_step_size;
    logic                   o_busy;
    logic                   o_done;
    logic                   o_wrap;

    modport master (
        output i_start, i_abort, i_mode, i_start_step, i_stop_step, i_delta, i_dwell,
        input  o_step_size, o_busy, o_done, o_wrap
    );

    modport slave (
        input  i_start, i_abort, i_mode, i_start_step, i_stop_step, i_delta, i_dwell,
        output o_step_size, o_busy, o_done, o_wrap
    );

endinterface

// File: rtl/sweep_controller_dwell_timer.sv
// Dwell period timer: down-counter that marks the last cycle of each dwell
// period.
//   i_clk, i_res : clock, synchronous active-low reset
//   start_i      : load the period (dwell_i - 1) and begin a new period
//   abort_i      : clear the counter
//   run_i        : count while the sweep is active
//   dwell_i      : dwell length, already normalised to >= 1
//   tick_o       : high for the single cycle that ends a period
module dwell_timer #(
    parameter int DWELL_WIDTH = 16
) (
    input  logic                   i_clk,
    input  logic                   i_res,
    input  logic                   start_i,
    input  logic                   abort_i,
    input  logic                   run_i,
    input  logic [DWELL_WIDTH-1:0] dwell_i,
    output logic                   tick_o
);

    localparam logic [DWELL_WIDTH-1:0] ONE = DWELL_WIDTH'(1);

    logic [DWELL_WIDTH-1:0] cnt_q;
    logic [DWELL_WIDTH-1:0] reload_q;

    // The counter holds the cycles left in the period; zero is the last one,
    // so a dwell of D produces a tick D edges after the load.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge i_clk) begin
        if (!i_res) begin
            cnt_q    <= '0;
            reload_q <= '0;
        end else if (abort_i) begin
            cnt_q    <= '0;
        end else if (start_i) begin
            reload_q <= dwell_i - ONE;
            cnt_q    <= dwell_i - ONE;
        end else if (run_i) begin
            cnt_q    <= (cnt_q == '0) ? reload_q : cnt_q - ONE;
        end
    end

    assign tick_o = run_i && (cnt_q == '0);

endmodule

// File: rtl/sweep_controller.sv
// Linear sweep (chirp) sequencer driving the generator's step_size input.
//   i_clk, i_res : clock, synchronous active-low reset
//   bus          : sweep_controller_if slave (config in, step/status out)
// Walks o_step_size from start to stop by delta every dwell period in
// single, repeat or bounce mode. All outputs are registered.
module sweep_controller
    import sweep_pkg::*;
#(
    parameter int ADDRESS_SIZE = 8,
    parameter int PRECISION    = 16,
    parameter int DWELL_WIDTH  = 16
) (
    input logic               i_clk,
    input logic               i_res,
    sweep_controller_if.slave bus
);

    localparam int STEP_W = ADDRESS_SIZE + PRECISION;

    state_e            state_q, state_d;
    mode_e             mode_q, mode_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [STEP_W-1:0] target_q, target_d;
    logic [STEP_W-1:0] origin_q, origin_d;
    logic [STEP_W-1:0] delta_q, delta_d;
    logic              dir_up_q, dir_up_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              wrap_q, wrap_d;

    logic start_accept;
    logic tick;

    // One delta toward tgt, computed one bit wider so a carry or borrow is
    // seen and clamped to the target instead of wrapping.
    function automatic logic [STEP_W-1:0] step_toward(
        input logic [STEP_W-1:0] cur,
        input logic [STEP_W-1:0] tgt,
        input logic [STEP_W-1:0] dlt,
        input logic              up
    );
        logic [STEP_W:0] wide;
        if (up) begin
            wide = {1'b0, cur} + {1'b0, dlt};
            return (wide > {1'b0, tgt}) ? tgt : wide[STEP_W-1:0];
        end
        wide = {1'b0, cur} - {1'b0, dlt};
        return (wide[STEP_W] || (wide < {1'b0, tgt})) ? tgt : wide[STEP_W-1:0];
    endfunction

    // Abort beats a simultaneous start.
    assign start_accept = (state_q == IDLE) && bus.i_start && !bus.i_abort;

    dwell_timer #(.DWELL_WIDTH(DWELL_WIDTH)) u_dwell_timer (
        .i_clk   (i_clk),
        .i_res   (i_res),
        .start_i (start_accept),
        .abort_i (bus.i_abort),
        .run_i   (state_q == SWEEP),
        .dwell_i (DWELL_WIDTH'(norm_dwell(32'(bus.i_dwell)))),
        .tick_o  (tick)
    );

    always_ff @(posedge i_clk) begin
        if (!i_res) begin
            state_q  <= IDLE;
            mode_q   <= SINGLE;
            step_q   <= '0;
            target_q <= '0;
            origin_q <= '0;
            delta_q  <= '0;
            dir_up_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            wrap_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            step_q   <= step_d;
            target_q <= target_d;
            origin_q <= origin_d;
            delta_q  <= delta_d;
            dir_up_q <= dir_up_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            wrap_q   <= wrap_d;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path through
    // the case statements can leave one unassigned and infer a latch.
    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        step_d   = step_q;
        target_d = target_q;
        origin_d = origin_q;
        delta_d  = delta_q;
        dir_up_d = dir_up_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        wrap_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_accept) begin
                    state_d  = SWEEP;
                    mode_d   = to_mode(bus.i_mode);
                    step_d   = bus.i_start_step;
                    origin_d = bus.i_start_step;
                    target_d = bus.i_stop_step;
                    delta_d  = bus.i_delta;
                    dir_up_d = (bus.i_stop_step >= bus.i_start_step);
                    busy_d   = 1'b1;
                end
            end
            SWEEP: begin
                if (bus.i_abort) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else if (tick) begin
                    if (step_q != target_q) begin
                        step_d = step_toward(step_q, target_q, delta_q, dir_up_q);
                    end else begin
                        // Endpoint has now been held for one full dwell.
                        case (mode_q)
                            REPEAT: begin
                                step_d = origin_q;
                                wrap_d = 1'b1;
                            end
                            BOUNCE: begin
                                target_d = origin_q;
                                origin_d = target_q;
                                dir_up_d = !dir_up_q;
                                step_d   = step_toward(step_q, origin_q, delta_q, !dir_up_q);
                                wrap_d   = 1'b1;
                            end
                            default: begin
                                state_d = DONE;
                                busy_d  = 1'b0;
                                done_d  = 1'b1;
                            end
                        endcase
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.o_step_size = step_q;
    assign bus.o_busy      = busy_q;
    assign bus.o_done      = done_q;
    assign bus.o_wrap      = wrap_q;

endmodule

// File: tb/tb_sweep_controller.sv
// Scoreboard bench for sweep_controller. The driver issues directed sweeps
// and queues the hand-computed output expected after a given clock edge; the
// monitor samples on the falling edge and compares whatever falls due.
module tb_sweep_controller;

    localparam int STEP_W = 24;

    typedef struct packed {
        int unsigned       cyc;
        logic [STEP_W-1:0] step;
        logic              busy;
        logic              done;
        logic              wrap;
    } exp_t;

    logic        clk = 1'b0;
    logic        res_n;
    int unsigned cyc = 0;
    int unsigned k;
    int          n_pass = 0;
    int          n_total = 0;

    exp_t  exp_q[$];
    string name_q[$];
    exp_t  cur_e;
    string cur_n;

    sweep_controller_if #(.STEP_W(STEP_W), .DWELL_WIDTH(16)) bus ();

    sweep_controller #(
        .ADDRESS_SIZE (8),
        .PRECISION    (16),
        .DWELL_WIDTH  (16)
    ) dut (
        .i_clk (clk),
        .i_res (res_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [26:0] act, input logic [26:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s @edge %0d: got step=%h busy=%b done=%b wrap=%b, want step=%h busy=%b done=%b wrap=%b",
                      name, cyc, act[26:3], act[2], act[1], act[0], exp[26:3], exp[2], exp[1], exp[0]);
    endtask

    // Expected outputs right after clock edge c.
    task automatic exp_at(input int unsigned c, input logic [STEP_W-1:0] step,
                          input logic b, input logic d, input logic w, input string name);
        exp_t e;
        e.cyc = c; e.step = step; e.busy = b; e.done = d; e.wrap = w;
        exp_q.push_back(e);
        name_q.push_back(name);
    endtask

    task automatic cfg(input logic [1:0] m, input logic [STEP_W-1:0] s, input logic [STEP_W-1:0] e,
                       input logic [STEP_W-1:0] d, input logic [15:0] dw);
        bus.i_mode = m; bus.i_start_step = s; bus.i_stop_step = e;
        bus.i_delta = d; bus.i_dwell = dw;
    endtask

    // Return at the falling edge just before clock edge c.
    task automatic before_edge(input int unsigned c);
        while (cyc + 1 < c) @(negedge clk);
    endtask

    task automatic pulse_abort(input int unsigned c);
        before_edge(c);
        bus.i_abort = 1'b1;
        @(negedge clk);
        bus.i_abort = 1'b0;
    endtask

    // Monitor: compares every expectation whose edge has arrived.
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            cur_e = exp_q.pop_front();
            cur_n = name_q.pop_front();
            if (cur_e.cyc < cyc) begin
                n_total++;
                $display("FAIL %s: expectation for edge %0d missed, now edge %0d", cur_n, cur_e.cyc, cyc);
            end else begin
                check(cur_n, {bus.o_step_size, bus.o_busy, bus.o_done, bus.o_wrap},
                      {cur_e.step, cur_e.busy, cur_e.done, cur_e.wrap});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        res_n = 1'b0;
        bus.i_start = 1'b0;
        bus.i_abort = 1'b0;
        cfg(2'd0, '0, '0, '0, 16'd0);

        // Reset, then idle.
        @(negedge clk);
        k = cyc + 1;
        exp_at(k,     24'h0, 0, 0, 0, "reset");
        exp_at(k + 1, 24'h0, 0, 0, 0, "idle_after_reset");
        @(negedge clk);
        res_n = 1'b1;
        before_edge(k + 3);

        // Single up, dwell 2, with ignored restart and config change mid-sweep.
        cfg(2'd0, 24'h000100, 24'h000400, 24'h000100, 16'd2);
        bus.i_start = 1'b1;
        k = cyc + 1;
        exp_at(k,     24'h000100, 1, 0, 0, "up_k0");
        exp_at(k + 1, 24'h000100, 1, 0, 0, "up_k1");
        exp_at(k + 2, 24'h000200, 1, 0, 0, "up_k2");
        exp_at(k + 3, 24'h000200, 1, 0, 0, "up_k3");
        exp_at(k + 4, 24'h000300, 1, 0, 0, "up_k4");
        exp_at(k + 6, 24'h000400, 1, 0, 0, "up_k6");
        exp_at(k + 7, 24'h000400, 1, 0, 0, "up_k7");
        exp_at(k + 8, 24'h000400, 0, 1, 0, "up_done");
        exp_at(k + 9, 24'h000400, 0, 0, 0, "up_after_done");
        @(negedge clk);
        cfg(2'd1, 24'h0, 24'h000800, 24'h000300, 16'd1);
        @(negedge clk);
        bus.i_start = 1'b0;
        before_edge(k + 11);

        // Clamped down sweep, mode 3 behaves as single.
        cfg(2'd3, 24'h000250, 24'h000000, 24'h000100, 16'd1);
        bus.i_start = 1'b1;
        k = cyc + 1;
        exp_at(k,     24'h000250, 1, 0, 0, "down_k0");
        exp_at(k + 1, 24'h000150, 1, 0, 0, "down_k1");
        exp_at(k + 2, 24'h000050, 1, 0, 0, "down_k2");
        exp_at(k + 3, 24'h000000, 1, 0, 0, "down_clamp");
        exp_at(k + 4, 24'h000000, 0, 1, 0, "down_done");
        exp_at(k + 5, 24'h000000, 0, 0, 0, "down_after_done");
        @(negedge clk);
        bus.i_start = 1'b0;
        before_edge(k + 7);

        // Repeat mode, then abort right after a reload.
        cfg(2'd1, 24'h10, 24'h30, 24'h10, 16'd1);
        bus.i_start = 1'b1;
        k = cyc + 1;
        exp_at(k,     24'h10, 1, 0, 0, "rep_k0");
        exp_at(k + 1, 24'h20, 1, 0, 0, "rep_k1");
        exp_at(k + 2, 24'h30, 1, 0, 0, "rep_k2");
        exp_at(k + 3, 24'h10, 1, 0, 1, "rep_wrap1");
        exp_at(k + 4, 24'h20, 1, 0, 0, "rep_k4");
        exp_at(k + 5, 24'h30, 1, 0, 0, "rep_k5");
        exp_at(k + 6, 24'h10, 1, 0, 1, "rep_wrap2");
        exp_at(k + 7, 24'h10, 0, 0, 0, "rep_abort");
        exp_at(k + 8, 24'h10, 0, 0, 0, "rep_idle");
        @(negedge clk);
        bus.i_start = 1'b0;
        pulse_abort(k + 7);
        before_edge(k + 10);

        // Bounce mode with dwell 0 (acts as dwell 1).
        cfg(2'd2, 24'h10, 24'h30, 24'h10, 16'd0);
        bus.i_start = 1'b1;
        k = cyc + 1;
        exp_at(k,     24'h10, 1, 0, 0, "bnc_k0");
        exp_at(k + 1, 24'h20, 1, 0, 0, "bnc_k1");
        exp_at(k + 2, 24'h30, 1, 0, 0, "bnc_k2");
        exp_at(k + 3, 24'h20, 1, 0, 1, "bnc_rev_top");
        exp_at(k + 4, 24'h10, 1, 0, 0, "bnc_k4");
        exp_at(k + 5, 24'h20, 1, 0, 1, "bnc_rev_bottom");
        exp_at(k + 6, 24'h30, 1, 0, 0, "bnc_k6");
        exp_at(k + 7, 24'h20, 1, 0, 1, "bnc_rev_top2");
        exp_at(k + 8, 24'h20, 0, 0, 0, "bnc_abort");
        @(negedge clk);
        bus.i_start = 1'b0;
        pulse_abort(k + 8);
        before_edge(k + 10);

        // Abort mid-sweep while the step sits at 0x200; no done afterwards.
        cfg(2'd0, 24'h000100, 24'h000400, 24'h000100, 16'd3);
        bus.i_start = 1'b1;
        k = cyc + 1;
        exp_at(k,     24'h000100, 1, 0, 0, "abt_k0");
        exp_at(k + 2, 24'h000100, 1, 0, 0, "abt_k2");
        exp_at(k + 3, 24'h000200, 1, 0, 0, "abt_k3");
        exp_at(k + 4, 24'h000200, 0, 0, 0, "abt_hold");
        exp_at(k + 9, 24'h000200, 0, 0, 0, "abt_no_done");
        @(negedge clk);
        bus.i_start = 1'b0;
        pulse_abort(k + 4);
        before_edge(k + 11);

        // Start and abort together in IDLE: abort wins.
        cfg(2'd0, 24'h000777, 24'h000999, 24'h000001, 16'd1);
        bus.i_start = 1'b1;
        bus.i_abort = 1'b1;
        k = cyc + 1;
        exp_at(k,     24'h000200, 0, 0, 0, "startabort_k0");
        exp_at(k + 2, 24'h000200, 0, 0, 0, "startabort_k2");
        @(negedge clk);
        bus.i_start = 1'b0;
        bus.i_abort = 1'b0;
        before_edge(k + 4);

        // start == stop, single: done one dwell after start.
        cfg(2'd0, 24'h55, 24'h55, 24'h10, 16'd1);
        bus.i_start = 1'b1;
        k = cyc + 1;
        exp_at(k,     24'h55, 1, 0, 0, "eq_k0");
        exp_at(k + 1, 24'h55, 0, 1, 0, "eq_done");
        exp_at(k + 2, 24'h55, 0, 0, 0, "eq_after");
        @(negedge clk);
        bus.i_start = 1'b0;
        before_edge(k + 4);

        // delta 0 with start != stop: holds until abort.
        cfg(2'd0, 24'h10, 24'h20, 24'h0, 16'd1);
        bus.i_start = 1'b1;
        k = cyc + 1;
        exp_at(k,     24'h10, 1, 0, 0, "d0_k0");
        exp_at(k + 3, 24'h10, 1, 0, 0, "d0_k3");
        exp_at(k + 6, 24'h10, 1, 0, 0, "d0_k6");
        exp_at(k + 7, 24'h10, 0, 0, 0, "d0_abort");
        @(negedge clk);
        bus.i_start = 1'b0;
        pulse_abort(k + 7);
        before_edge(k + 9);

        // Top of range: sum would carry out, must clamp to stop.
        cfg(2'd0, 24'hFFFF00, 24'hFFFFFF, 24'h000200, 16'd1);
        bus.i_start = 1'b1;
        k = cyc + 1;
        exp_at(k,     24'hFFFF00, 1, 0, 0, "top_k0");
        exp_at(k + 1, 24'hFFFFFF, 1, 0, 0, "top_clamp");
        exp_at(k + 2, 24'hFFFFFF, 0, 1, 0, "top_done");
        @(negedge clk);
        bus.i_start = 1'b0;
        before_edge(k + 4);

        // Reset mid-sweep overrides a concurrent start.
        cfg(2'd0, 24'h000100, 24'h000400, 24'h000100, 16'd1);
        bus.i_start = 1'b1;
        k = cyc + 1;
        exp_at(k,     24'h000100, 1, 0, 0, "rst_k0");
        exp_at(k + 2, 24'h000300, 1, 0, 0, "rst_k2");
        exp_at(k + 3, 24'h000000, 0, 0, 0, "rst_mid");
        exp_at(k + 4, 24'h000000, 0, 0, 0, "rst_released");
        @(negedge clk);
        bus.i_start = 1'b0;
        before_edge(k + 3);
        res_n = 1'b0;
        bus.i_start = 1'b1;
        @(negedge clk);
        res_n = 1'b1;
        bus.i_start = 1'b0;
        before_edge(k + 6);
        repeat (2) @(negedge clk);

        while (exp_q.size() > 0) begin
            cur_e = exp_q.pop_front();
            cur_n = name_q.pop_front();
            n_total++;
            $display("FAIL %s: expectation for edge %0d never compared", cur_n, cur_e.cyc);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
